// File: rtl/mem_run_ctrl.sv
// mem_run_ctrl: preloads sram from the load port with the cpu held in reset, runs the cpu until halt or cycle limit, then streams an sram window out on the dump port
module mem_run_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int CYCLE_WIDTH  = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYCLE_WIDTH-1:0] run_limit,
  input  logic [ADDR_WIDTH-1:0]  dump_base,
  input  logic [ADDR_WIDTH-1:0]  dump_count,
  input  logic                   load_valid,
  input  logic                   load_last,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   load_ready,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_data_out,
  input  logic                   cpu_we_n,
  input  logic                   cpu_halt,
  output logic                   cpu_rst,
  output logic [DATA_WIDTH-1:0]  cpu_data_in,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_data_out,
  output logic                   mem_we_n,
  input  logic [DATA_WIDTH-1:0]  mem_data_in,
  output logic                   dump_valid,
  output logic [ADDR_WIDTH-1:0]  dump_addr,
  output logic [DATA_WIDTH-1:0]  dump_data,
  input  logic                   dump_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CYCLE_WIDTH-1:0] cycles_used
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE} state_t;
  localparam logic [CYCLE_WIDTH-1:0] CYC_ONE   = CYCLE_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [2:0]             WAIT_LAST = 3'(READ_LATENCY - 1);
  state_t                 state_q, state_d;
  logic [CYCLE_WIDTH-1:0] limit_q, limit_d, cycles_q, cycles_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d, idx_q, idx_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [2:0]             wait_q, wait_d;
  logic                   timeout_q, timeout_d;
  logic                   run_end;
  assign run_end = cpu_halt | (limit_q != '0 && cycles_q + CYC_ONE == limit_q);
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    cycles_d  = cycles_q;
    count_d   = count_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d   = LOAD;
        limit_d   = run_limit;
        count_d   = dump_count;
        addr_d    = dump_base;
        idx_d     = '0;
        cycles_d  = '0;
        timeout_d = 1'b0;
      end
      LOAD: state_d = load_valid && load_last ? RUN : LOAD;
      RUN: begin
        cycles_d = &cycles_q ? cycles_q : cycles_q + CYC_ONE;
        if (run_end) begin
          timeout_d = ~cpu_halt;
          state_d   = count_q == '0 ? DONE : DUMP_REQ;
        end
      end
      DUMP_REQ: begin
        state_d = DUMP_WAIT;
        wait_d  = '0;
      end
      DUMP_WAIT: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == WAIT_LAST) begin
          data_d  = mem_data_in;
          state_d = DUMP_OUT;
        end
      end
      DUMP_OUT: if (dump_ready) begin
        idx_d   = idx_q + ADDR_ONE;
        addr_d  = addr_q + ADDR_ONE;
        state_d = idx_q + ADDR_ONE == count_q ? DONE : DUMP_REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      cycles_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      cycles_q  <= cycles_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign load_ready   = state_q == LOAD;
  assign cpu_rst      = state_q != RUN;
  assign cpu_data_in  = mem_data_in;
  assign mem_we_n     = state_q == LOAD ? ~load_valid : state_q == RUN ? cpu_we_n : 1'b1;
  assign mem_addr     = state_q == LOAD ? load_addr : state_q == RUN ? cpu_addr : addr_q;
  assign mem_data_out = state_q == LOAD ? load_data : state_q == RUN ? cpu_data_out : '0;
  assign dump_valid   = state_q == DUMP_OUT;
  assign dump_addr    = addr_q;
  assign dump_data    = data_q;
  assign busy         = state_q != IDLE && state_q != DONE;
  assign done         = state_q == DONE;
  assign timeout      = timeout_q;
  assign cycles_used  = cycles_q;
endmodule

// File: tb/tb_mem_run_ctrl.sv
// tb_mem_run_ctrl: randomized sessions against a behavioural sram/cpu/session model
module tb_mem_run_ctrl;
  localparam int RL = 2;
  logic        clk, reset, start;
  logic [15:0] run_limit, dump_base, dump_count;
  logic        load_valid, load_last, load_ready;
  logic [15:0] load_addr, load_data;
  logic [15:0] cpu_addr, cpu_data_out, cpu_data_in;
  logic        cpu_we_n, cpu_halt, cpu_rst;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        mem_we_n;
  logic        dump_valid, dump_ready;
  logic [15:0] dump_addr, dump_data;
  logic        busy, done, timeout;
  logic [15:0] cycles_used;
  int n_run = 0, n_fail = 0;
  logic [15:0] sram [65536];
  logic [15:0] rd_pipe [RL];
  logic [15:0] rmem [int];
  logic [15:0] q_addr [$], q_data [$];

  mem_run_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .CYCLE_WIDTH(16), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .run_limit(run_limit), .dump_base(dump_base),
    .dump_count(dump_count), .load_valid(load_valid), .load_last(load_last), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we_n(cpu_we_n), .cpu_halt(cpu_halt), .cpu_rst(cpu_rst), .cpu_data_in(cpu_data_in),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_we_n(mem_we_n), .mem_data_in(mem_data_in),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_ready(dump_ready),
    .busy(busy), .done(done), .timeout(timeout), .cycles_used(cycles_used));

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr] <= mem_data_out;
    rd_pipe[0] <= sram[mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_in = rd_pipe[RL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_valid"}, dump_valid, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_we_n"}, mem_we_n, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ldrdy"}, load_ready, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cycles"}, cycles_used, 0);
    check({tag, "_addr"}, mem_addr, 0);
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  task automatic rand_beats(input logic [15:0] base, input int cnt, input int n);
    for (int i = 0; i < n; i++) beat(base + 16'($urandom_range(0, cnt)), 16'($urandom));
  endtask

  task automatic session(input int limit, input int halt_at, input logic [15:0] base, input int cnt,
                         input int rmode, input bit cpu_wr, input bit gaps, input int rst_at);
    int ld_rdy, ld_slots, run_seen, vcyc, k, exp_len;
    bit halt_first, exp_to, pend;
    logic [15:0] p_addr, p_data, a;
    logic [15:0] b_addr [$], b_data [$];
    bit pat [4] = '{1, 0, 0, 1};
    ld_rdy = 0; ld_slots = 0; run_seen = 0; vcyc = 0; pend = 0;
    halt_first = halt_at != 0 && (limit == 0 || halt_at <= limit);
    exp_len = halt_first ? halt_at : limit;
    exp_to = !halt_first;
    @(negedge clk);
    start = 1; run_limit = 16'(limit); dump_base = base; dump_count = 16'(cnt);
    @(negedge clk);
    start = 0; run_limit = 16'($urandom); dump_base = 16'($urandom); dump_count = 16'($urandom);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_cycles", cycles_used, 0);
    check("start_timeout", timeout, 0);
    for (int i = 0; i < q_addr.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        ld_rdy += int'(load_ready); ld_slots++; load_valid = 0;
        @(negedge clk);
      end
      if (rst_at == 1 && i == 1) begin
        load_valid = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        idle_checks("rst_load");
        load_valid = 1; load_last = 0; load_addr = 16'h0200; load_data = 16'hDEAD;
        repeat (2) begin
          @(negedge clk);
          check("ghost_we_n", mem_we_n, 1);
          check("ghost_ldrdy", load_ready, 0);
        end
        load_valid = 0;
        q_addr.delete(); q_data.delete();
        return;
      end
      ld_rdy += int'(load_ready); ld_slots++;
      load_valid = 1; load_last = i == q_addr.size() - 1; load_addr = q_addr[i]; load_data = q_data[i];
      rmem[int'(q_addr[i])] = q_data[i];
      @(negedge clk);
    end
    load_valid = 0; load_last = 0;
    q_addr.delete(); q_data.delete();
    for (int c = 0; c < 2000; c++) begin
      start = 0;
      if (done) break;
      ld_rdy += int'(load_ready);
      if (!cpu_rst) begin
        k = run_seen++;
        cpu_halt = halt_at != 0 && k >= halt_at - 1;
        start = 1'($urandom_range(0, 1));
        run_limit = 16'($urandom); dump_base = 16'($urandom); dump_count = 16'($urandom);
        cpu_addr = 16'($urandom); cpu_data_out = 16'($urandom); cpu_we_n = 1;
        if (cpu_wr && cnt > 0 && $urandom_range(0, 1) == 1) begin
          cpu_we_n = 0;
          cpu_addr = base + 16'($urandom_range(0, cnt - 1));
          if (k < exp_len) rmem[int'(cpu_addr)] = cpu_data_out;
        end
      end else begin
        cpu_halt = 0; cpu_we_n = 1;
      end
      dump_ready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[vcyc % 4] : 1'($urandom_range(0, 1));
      if (pend && !dump_valid) begin
        check("valid_held", dump_valid, 1);
        pend = 0;
      end
      if (dump_valid) begin
        if (rst_at == 2) begin
          reset = 1; dump_ready = 0;
          @(negedge clk);
          reset = 0;
          idle_checks("rst_dump");
          return;
        end
        if (pend) begin
          check("stall_addr", dump_addr, p_addr);
          check("stall_data", dump_data, p_data);
        end
        vcyc++;
        if (dump_ready) begin
          b_addr.push_back(dump_addr); b_data.push_back(dump_data); pend = 0;
        end else begin
          pend = 1; p_addr = dump_addr; p_data = dump_data;
        end
      end
      @(negedge clk);
    end
    start = 0; dump_ready = 0; cpu_halt = 0; cpu_we_n = 1;
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_cpu_rst", cpu_rst, 1);
    check("done_we_n", mem_we_n, 1);
    check("run_len", run_seen, exp_len);
    check("cycles_used", cycles_used, exp_len);
    check("timeout", timeout, exp_to);
    check("ldrdy_cycles", ld_rdy, ld_slots);
    check("beats", b_addr.size(), cnt);
    if (cnt == 0) check("no_valid", vcyc, 0);
    for (int j = 0; j < b_addr.size() && j < cnt; j++) begin
      a = base + 16'(j);
      check($sformatf("dump_addr%0d", j), b_addr[j], a);
      if (rmem.exists(int'(a))) check($sformatf("dump_data%0d", j), b_data[j], rmem[int'(a)]);
    end
  endtask

  initial begin
    reset = 1; start = 0; run_limit = 0; dump_base = 0; dump_count = 0;
    load_valid = 0; load_last = 0; load_addr = 0; load_data = 0;
    cpu_addr = 0; cpu_data_out = 0; cpu_we_n = 1; cpu_halt = 0; dump_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_checks("reset");
    check("reset_data_out", mem_data_out, 0);
    reset = 0;
    beat(16'd0, 16'h7800); beat(16'd1, 16'h7001); beat(16'd100, 16'h0005);
    session(0, 12, 16'd100, 1, 0, 0, 0, 0);
    rand_beats(16'h1000, 5, 4);
    session(50, 0, 16'h1000, 5, 2, 1, 1, 0);
    rand_beats(16'h2000, 3, 3);
    session(50, 50, 16'h2000, 3, 0, 1, 1, 0);
    beat(16'hFFFE, 16'hA001); beat(16'hFFFF, 16'hA002); beat(16'h0000, 16'hA003); beat(16'h0001, 16'hA004);
    session(20, 7, 16'hFFFE, 4, 1, 1, 0, 0);
    rand_beats(16'h0040, 2, 2);
    session(10, 3, 16'h0040, 0, 0, 1, 0, 0);
    beat(16'h0200, 16'h1234); beat(16'h0201, 16'h7777);
    session(0, 5, 16'h0200, 2, 0, 0, 0, 0);
    beat(16'h0201, 16'hABCD); beat(16'h0202, 16'h1111); beat(16'h0203, 16'h2222);
    session(0, 5, 16'h0200, 2, 0, 0, 0, 1);
    beat(16'h0300, 16'h5555);
    session(0, 4, 16'h0200, 2, 0, 0, 0, 0);
    rand_beats(16'h0010, 3, 3);
    session(5, 0, 16'h0010, 3, 0, 1, 1, 2);
    rand_beats(16'h0500, 2, 2);
    session(1, 0, 16'h0500, 2, 2, 1, 1, 0);
    for (int s = 0; s < 6; s++) begin
      int lim, h, cnt;
      logic [15:0] b;
      lim = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
      h = $urandom_range(1, 40);
      cnt = $urandom_range(0, 6);
      b = 16'($urandom);
      rand_beats(b, cnt, $urandom_range(1, 5));
      session(lim, h, b, cnt, 2, 1, 1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
